// File: rtl/patdet_cfg.sv
// Configurable serial pattern detector: runtime pattern/length, optional overlap,
// pulsed or sticky match flag, saturating match counter and config-error pulse.
module patdet_cfg #(
    parameter int                MAXLEN  = 8,
    parameter int                LENW    = 4,
    parameter int                CNTW    = 8,
    parameter logic [MAXLEN-1:0] DEF_PAT = 8'b0001_0010,
    parameter int                DEF_LEN = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              e,
    input  logic              ev,
    input  logic              clr,
    input  logic              cfg_we,
    input  logic [MAXLEN-1:0] cfg_pat,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_ovl,
    input  logic              cfg_sticky,
    output logic              s,
    output logic [CNTW-1:0]   cnt,
    output logic              cfg_err,
    output logic              dbg_state
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t            r_state;
    logic [MAXLEN-1:0] r_h;
    logic [LENW-1:0]   r_fill;
    logic              r_s;
    logic [CNTW-1:0]   r_cnt;
    logic              r_err;
    logic [MAXLEN-1:0] r_pat;
    logic [LENW-1:0]   r_len;
    logic              r_ovl;
    logic              r_sticky;

    logic              w_accept;
    logic [MAXLEN-1:0] w_h_next;
    logic [LENW-1:0]   w_fill_next;
    logic [MAXLEN-1:0] w_mask;
    logic              w_match;
    logic              w_cfg_ok;

    // ev is a valid with no ready: a bit is taken only in RUN on a cycle free of
    // clr/cfg_we; any other presented bit is silently dropped.
    assign w_accept    = ev && (r_state == RUN) && !clr && !cfg_we;
    assign w_h_next    = {r_h[MAXLEN-2:0], e};
    assign w_fill_next = (r_fill == LENW'(MAXLEN)) ? r_fill : r_fill + 1'b1;
    assign w_cfg_ok    = (cfg_len != '0) && (cfg_len <= LENW'(MAXLEN));

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_accept && (w_fill_next >= r_len)
                     && (((w_h_next ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= RUN;
            r_h      <= '0;
            r_fill   <= '0;
            r_s      <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_pat    <= DEF_PAT;
            r_len    <= LENW'(DEF_LEN);
            r_ovl    <= 1'b0;
            r_sticky <= 1'b1;
        end else begin
            r_err <= 1'b0;
            // Pulse mode: s drops back unless this edge matches again.
            if (r_state == RUN) begin
                r_s <= 1'b0;
            end
            if (w_accept) begin
                r_h    <= w_h_next;
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_next;
            end
            if (w_match) begin
                r_s <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (r_sticky) begin
                    r_state <= HOLD;
                end
            end
            if (clr) begin
                r_h     <= '0;
                r_fill  <= '0;
                r_s     <= 1'b0;
                r_cnt   <= '0;
                r_state <= RUN;
            end
            if (cfg_we) begin
                if (w_cfg_ok) begin
                    r_pat    <= cfg_pat;
                    r_len    <= cfg_len;
                    r_ovl    <= cfg_ovl;
                    r_sticky <= cfg_sticky;
                    r_h      <= '0;
                    r_fill   <= '0;
                    r_s      <= 1'b0;
                    r_state  <= RUN;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign s         = r_s;
    assign cnt       = r_cnt;
    assign cfg_err   = r_err;
    assign dbg_state = r_state;

endmodule
